// File: rtl/cnt_meas.sv
// cnt_meas: counts clk cycles between qualifying edges of the asynchronous input sig and reports interval-1.
// Optional build macro CNT_MEAS_AVG_EN reports the mean of the last four measurements instead of the raw value.
module cnt_meas #(
  parameter int unsigned WIDTH   = 32,
  parameter logic [31:0] TIMEOUT = 32'hFFFF_FFF0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig,
  input  logic [2:0]       control,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             ovf,
  output logic             stalled
);

  typedef enum logic [2:0] {
    MODE_OFF  = 3'd0,
    MODE_EDGE = 3'd1,
    MODE_RISE = 3'd2
  } mode_e;

  localparam logic [WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);

  logic             r_s1, r_s2, r_s3;
  logic [2:0]       r_ctrl_q;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_dout;
  logic             r_armed;
  logic             r_valid;
  logic             r_ovf;
  logic             r_stalled;

  logic w_edge_mode;
  logic w_rise_mode;
  logic w_restart;
  logic w_active;
  logic w_qe;

  // Mode is decoded from the registered copy; a cycle where control differs from it is a restart.
  assign w_edge_mode = (r_ctrl_q == MODE_EDGE);
  assign w_rise_mode = (r_ctrl_q == MODE_RISE);
  assign w_restart   = (control != r_ctrl_q);
  assign w_active    = (w_edge_mode || w_rise_mode) && !w_restart;
  assign w_qe        = (w_edge_mode && (r_s2 ^ r_s3)) || (w_rise_mode && r_s2 && !r_s3);

`ifdef CNT_MEAS_AVG_EN
  logic [WIDTH-1:0] r_win [4];
  logic [WIDTH+1:0] r_sum;
  logic [2:0]       r_nsamp;
  logic [WIDTH+1:0] w_sum_next;

  // Running sum: add the incoming sample, drop the one falling out of the window.
  assign w_sum_next = r_sum + {2'b00, r_cnt} - {2'b00, r_win[3]};
`endif

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it lives inside the clocked block and is only seen at a rising edge.
    if (!reset) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_s3      <= 1'b0;
      r_ctrl_q  <= '0;
      r_cnt     <= '0;
      r_dout    <= '0;
      r_armed   <= 1'b0;
      r_valid   <= 1'b0;
      r_ovf     <= 1'b0;
      r_stalled <= 1'b0;
`ifdef CNT_MEAS_AVG_EN
      // NOTE: the window is reset explicitly because the running sum subtracts its oldest entry.
      for (int i = 0; i < 4; i++) r_win[i] <= '0;
      r_sum     <= '0;
      r_nsamp   <= '0;
`endif
    end else begin
      // NOTE: s1/s2 resolve metastability on the asynchronous sig; s3 only provides the previous value.
      r_s1     <= sig;
      r_s2     <= r_s1;
      r_s3     <= r_s2;
      r_ctrl_q <= control;
      r_valid  <= 1'b0;

      if (!w_active) begin
        r_cnt     <= '0;
        r_armed   <= 1'b0;
        r_stalled <= 1'b0;
        if (w_restart) r_ovf <= 1'b0;
`ifdef CNT_MEAS_AVG_EN
        for (int i = 0; i < 4; i++) r_win[i] <= '0;
        r_sum   <= '0;
        r_nsamp <= '0;
`endif
      end else begin
        if (w_qe)                         r_stalled <= 1'b0;
        else if (r_cnt >= TIMEOUT_W)      r_stalled <= 1'b1;

        if (!w_qe) begin
          if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
        end else if (!r_armed) begin
          r_cnt   <= '0;
          r_armed <= 1'b1;
        end else begin
          r_cnt <= '0;
          if (r_cnt == CNT_MAX) r_ovf <= 1'b1;
`ifdef CNT_MEAS_AVG_EN
          r_win[0] <= r_cnt;
          r_win[1] <= r_win[0];
          r_win[2] <= r_win[1];
          r_win[3] <= r_win[2];
          r_sum    <= w_sum_next;
          if (r_nsamp != 3'd4) r_nsamp <= r_nsamp + 3'd1;
          if (r_nsamp >= 3'd3) begin
            r_dout  <= w_sum_next[WIDTH+1:2];
            r_valid <= 1'b1;
          end
`else
          r_dout  <= r_cnt;
          r_valid <= 1'b1;
`endif
        end
      end
    end
  end

  assign dout    = r_dout;
  assign valid   = r_valid;
  assign ovf     = r_ovf;
  assign stalled = r_stalled;

endmodule

// File: tb/tb_cnt_meas.sv
// Self-checking bench for cnt_meas: two instances (WIDTH=32 default, WIDTH=8/TIMEOUT=200) checked every cycle
// against a timestamp-based reference model; honours CNT_MEAS_AVG_EN when defined.
module tb_cnt_meas;

  logic        clk     = 1'b0;
  logic        reset   = 1'b0;
  logic        sig     = 1'b0;
  logic [2:0]  control = 3'd0;

  logic [31:0] dout32;
  logic        valid32, ovf32, stalled32;
  logic [7:0]  dout8;
  logic        valid8, ovf8, stalled8;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cnt_meas u_dut32 (
    .clk     (clk),
    .reset   (reset),
    .sig     (sig),
    .control (control),
    .dout    (dout32),
    .valid   (valid32),
    .ovf     (ovf32),
    .stalled (stalled32)
  );

  cnt_meas #(.WIDTH(8), .TIMEOUT(32'd200)) u_dut8 (
    .clk     (clk),
    .reset   (reset),
    .sig     (sig),
    .control (control),
    .dout    (dout8),
    .valid   (valid8),
    .ovf     (ovf8),
    .stalled (stalled8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 25)
        $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A sig change sampled at edge N is acted on at edge N+2. Each instance remembers the edge at which its
  // cycle count last restarted (t_ref); the interval seen by a qualifying edge at cycle E is E-1-t_ref.
  longint          cyc = 0;
  logic            h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;
  logic [2:0]      m_ctrl_q = 3'd0;
  longint          m_tref    [2];
  bit              m_armed   [2];
  longint unsigned m_dout    [2];
  bit              m_valid   [2];
  bit              m_ovf     [2];
  bit              m_stalled [2];
`ifdef CNT_MEAS_AVG_EN
  longint unsigned m_win [2][$];
`endif

  function automatic longint unsigned max_of(input int i);
    return (i == 0) ? 64'hFFFF_FFFF : 64'hFF;
  endfunction

  function automatic longint unsigned to_of(input int i);
    return (i == 0) ? 64'hFFFF_FFF0 : 64'd200;
  endfunction

  task automatic model_step();
    bit              qe;
    longint unsigned age;
    longint unsigned sum;
    cyc++;
    if (!reset) begin
      h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
      m_ctrl_q = 3'd0;
      for (int i = 0; i < 2; i++) begin
        m_tref[i] = cyc; m_armed[i] = 0; m_dout[i] = 0;
        m_valid[i] = 0; m_ovf[i] = 0; m_stalled[i] = 0;
`ifdef CNT_MEAS_AVG_EN
        m_win[i].delete();
`endif
      end
      return;
    end
    qe = (m_ctrl_q == 3'd1) ? (h2 != h3) : (m_ctrl_q == 3'd2) ? (h2 && !h3) : 1'b0;
    h3 = h2; h2 = h1; h1 = sig;
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 0;
      if (control != m_ctrl_q || !(m_ctrl_q == 3'd1 || m_ctrl_q == 3'd2)) begin
        if (control != m_ctrl_q) m_ovf[i] = 0;
        m_tref[i] = cyc; m_armed[i] = 0; m_stalled[i] = 0;
`ifdef CNT_MEAS_AVG_EN
        m_win[i].delete();
`endif
      end else begin
        age = longint'(cyc - 1 - m_tref[i]);
        if (age > max_of(i)) age = max_of(i);
        if (qe)                  m_stalled[i] = 0;
        else if (age >= to_of(i)) m_stalled[i] = 1;
        if (qe) begin
          if (m_armed[i]) begin
            if (age == max_of(i)) m_ovf[i] = 1;
`ifdef CNT_MEAS_AVG_EN
            m_win[i].push_back(age);
            if (m_win[i].size() > 4) void'(m_win[i].pop_front());
            if (m_win[i].size() == 4) begin
              sum = 0;
              foreach (m_win[i][k]) sum += m_win[i][k];
              m_dout[i]  = sum / 4;
              m_valid[i] = 1;
            end
`else
            m_dout[i]  = age;
            m_valid[i] = 1;
`endif
          end
          m_armed[i] = 1;
          m_tref[i]  = cyc;
        end
      end
    end
    m_ctrl_q = control;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every-cycle comparison, away from the active edge.
  initial forever begin
    @(negedge clk);
    check("dout32",    dout32,    m_dout[0]);
    check("valid32",   valid32,   m_valid[0]);
    check("ovf32",     ovf32,     m_ovf[0]);
    check("stalled32", stalled32, m_stalled[0]);
    check("dout8",     dout8,     m_dout[1]);
    check("valid8",    valid8,    m_valid[1]);
    check("ovf8",      ovf8,      m_ovf[1]);
    check("stalled8",  stalled8,  m_stalled[1]);
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic toggle_seq(input int gap, input int n);
    repeat (n) begin
      repeat (gap) @(negedge clk);
      sig = ~sig;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dout32"}, dout32, 64'd0);
    check({tag, "_valid32"}, valid32, 64'd0);
    check({tag, "_ovf32"}, ovf32, 64'd0);
    check({tag, "_stalled32"}, stalled32, 64'd0);
    check({tag, "_dout8"}, dout8, 64'd0);
    check({tag, "_ovf8"}, ovf8, 64'd0);
  endtask

  initial begin
    int r, gap;
    idle(4);
    check_all_zero("reset");
    reset = 1'b1;
    idle(2);

    // EDGE mode, sig toggles every 10 clk
    control = 3'd1;
    idle(5);
    toggle_seq(10, 8);
    idle(5);
    check("m1_model_dout", m_dout[0], 64'd9);
    check("m1_dout32", dout32, 64'd9);
    check("m1_dout8", dout8, 64'd9);
    check("m1_ovf32", ovf32, 64'd0);
    check("m1_stalled32", stalled32, 64'd0);

    // RISE mode, same sig rate
    control = 3'd2;
    toggle_seq(10, 12);
    idle(5);
    check("m2_model_dout", m_dout[0], 64'd19);
    check("m2_dout32", dout32, 64'd19);
    check("m2_dout8", dout8, 64'd19);

    // Slow sig: WIDTH=8 instance stalls and saturates
    control = 3'd1;
    toggle_seq(300, 3);
    idle(250);
    check("slow_stalled8_high", stalled8, 64'd1);
    check("slow_stalled32_low", stalled32, 64'd0);
    idle(50);
    sig = ~sig;
    idle(5);
    check("slow_stalled8_clear", stalled8, 64'd0);
    check("slow_ovf8", ovf8, 64'd1);
    check("slow_ovf32", ovf32, 64'd0);
`ifndef CNT_MEAS_AVG_EN
    check("slow_model_dout8", m_dout[1], 64'd255);
    check("slow_dout8", dout8, 64'd255);
    check("slow_dout32", dout32, 64'd299);
`endif
    toggle_seq(10, 4);
    idle(5);
    check("ovf8_sticky", ovf8, 64'd1);

    // Mode switch 1 -> 2 mid-stream clears ovf, then OFF holds dout
    control = 3'd2;
    idle(3);
    check("switch_ovf8_cleared", ovf8, 64'd0);
    toggle_seq(10, 12);
    idle(5);
    check("switch_dout32", dout32, 64'd19);
    check("switch_dout8", dout8, 64'd19);
    control = 3'd0;
    toggle_seq(10, 6);
    idle(5);
    check("off_dout32_hold", dout32, 64'd19);
    check("off_dout8_hold", dout8, 64'd19);
    check("off_stalled8", stalled8, 64'd0);

    // Reset pulse mid-measurement (sig left low so reset does not fake an edge)
    control = 3'd1;
    idle(3);
    toggle_seq(10, 4);
    idle(4);
    reset = 1'b0;
    idle(1);
    check_all_zero("midreset");
    reset = 1'b1;
    toggle_seq(10, 8);
    idle(5);
    check("postreset_dout32", dout32, 64'd9);

    // Randomised segments: mode changes (incl. 3..7), gaps down to 1 clk, occasional reset
    for (int s = 0; s < 40; s++) begin
      r = $urandom_range(0, 9);
      control = (r < 4) ? 3'd1 : (r < 8) ? 3'd2 : 3'($urandom_range(0, 7));
      gap = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(1, 40);
      toggle_seq(gap, $urandom_range(1, 12));
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
      end
    end

`ifdef CNT_MEAS_AVG_EN
    // Averaging: intervals 10,10,12,12 then 14
    control = 3'd0;
    sig     = 1'b0;
    idle(6);
    control = 3'd1;
    idle(5);
    toggle_seq(5, 1);
    toggle_seq(10, 2);
    toggle_seq(12, 2);
    idle(4);
    check("avg4_model_dout", m_dout[0], 64'd10);
    check("avg4_dout32", dout32, 64'd10);
    toggle_seq(10, 1);
    idle(4);
    check("avg5_model_dout", m_dout[0], 64'd11);
    check("avg5_dout32", dout32, 64'd11);
`endif

    idle(5);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cnt_meas.md
Name: cnt_meas

Overview:
- Measurement counterpart of the team's divider/toggle counter: it receives a toggling signal and recovers the divider value that produced it.
- Counts clk cycles between qualifying edges of the asynchronous input `sig` and reports the interval minus one on `dout`.
  - A counter in reset-and-toggle mode with divider D therefore reads back as D.
- Used in self-check loops and for monitoring external clock-like signals.

Parameters:
- WIDTH, 32, width of the counter, `dout` and the capture register.
- TIMEOUT, 32'hFFFF_FFF0, `cnt` value at which `stalled` asserts; must be ≤ 2^WIDTH-1.

Ports:
- clk  input  1  clock; rising edge only.
- reset  input  1  synchronous, active-low reset.
- sig  input  1  measured signal, asynchronous to clk.
- control  input  3  mode: 0 = OFF, 1 = EDGE (both edges), 2 = RISE (rising edges only), 3..7 = treated as OFF.
- dout  output  WIDTH  last measured interval minus one.
- valid  output  1  one-cycle pulse when `dout` is updated.
- ovf  output  1  sticky overflow flag.
- stalled  output  1  level: no qualifying edge for TIMEOUT cycles.

Behaviour:
- All state updates on posedge clk. Reset is sampled only at clk, with `reset == 0` active.
- Reset values: `dout` = 0, `valid` = 0, `ovf` = 0, `stalled` = 0. Internal state also resets: `cnt` = 0, `armed` = 0, sync flops s1/s2/s3 = 0, `ctrl_q` = 0.
- Synchroniser and edge detect:
  - Chain is s1 <= sig, s2 <= s1, s3 <= s2.
  - EDGE mode: qualifying edge `qe` = s2 ^ s3.
  - RISE mode: `qe` = s2 & ~s3.
- Mode register: `ctrl_q` <= control every cycle. If control != ctrl_q, that cycle acts as a restart: `cnt` <= 0, `armed` <= 0, `ovf` <= 0, `stalled` <= 0, no `valid`.
- OFF mode:
  - `cnt` = 0, `armed` = 0, `valid` = 0, `stalled` = 0.
  - `dout` and `ovf` hold their values.
  - Sync flops keep running.
- Active mode (EDGE or RISE), each cycle:
  - No `qe`: `cnt` <= `cnt` + 1, saturating at 2^WIDTH-1 (never wraps).
  - `qe` with `armed` = 0: `cnt` <= 0, `armed` <= 1, no `valid`. The first edge after arm only starts timing.
  - `qe` with `armed` = 1: `dout` <= `cnt`, `valid` <= 1, `cnt` <= 0.
    - If `cnt` == 2^WIDTH-1 at that moment, then `ovf` <= 1 and `dout` = all ones.
  - `stalled` <= 1 when `cnt` ≥ TIMEOUT. `stalled` clears on the next `qe`.
- Arithmetic: with edges k clocks apart, `dout` = k-1.
  - Minimum representable interval is 1 clock, giving `dout` = 0.
  - Edges closer together than the synchroniser resolves are lost. The block does not flag this.
- Latency: a `sig` change first sampled into s1 at clk edge N produces `valid` high after clk edge N+2 (visible during cycle N+2..N+3).
- `valid` is never high for two consecutive cycles unless `sig` toggles every clk in EDGE mode. In that case each pulse carries `dout` = 0.
- Reset mid-operation: all state is cleared, so the next measurement needs two fresh qualifying edges.

Optional Feature:
- Macro: CNT_MEAS_AVG_EN.
- Defined:
  - Keeps a 4-entry sliding window of raw measurements and a sample count (0..4).
  - `dout` = (sum of the 4 entries) >> 2, truncated. The sum register is WIDTH+2 bits.
  - `valid` pulses only once 4 raw samples have been captured since arm; after that it pulses on every raw sample.
  - The window and sample count clear on reset, mode change and OFF.
  - `ovf` is unchanged: set if any raw sample saturates.
- Undefined: `dout` is the raw measurement, as described above. The window logic is absent.

Test Plan:
- Mode 1, `sig` toggles every 10 clk -> first `valid` on the 2nd edge after the change into mode 1; `dout` = 9 on every `valid`; `ovf` = 0; `stalled` = 0.
- Mode 2, same `sig` -> `valid` once per 20 clk; `dout` = 19.
- WIDTH=8, TIMEOUT=200, mode 1, `sig` toggles every 300 clk:
  - `stalled` rises once `cnt` reaches 200.
  - At the edge: `dout` = 255, `ovf` = 1, `stalled` clears.
  - `ovf` stays set.
- Mid-measurement, drive `reset` low for 1 clk -> all outputs 0. After release, the first edge gives no `valid` and the second edge gives a correct `dout`.
- Switch control 1 -> 2 mid-stream -> no `valid` until two rising edges in the new mode; `ovf` cleared. Then control -> 0 -> `dout` holds its last value and no `valid` occurs.
- CNT_MEAS_AVG_EN defined, mode 1, intervals 10, 10, 12, 12 clk -> no `valid` for the first 3 samples; the 4th gives `dout` = (9+9+11+11)/4 = 10. A further interval of 14 clk gives `dout` = (9+11+11+13)/4 = 11.
